// File: rtl/rsa_sram_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// rsa_sram_fetch_ctrl_if
//
// Bundles the two buses owned by the RSA operand fetch sequencer:
//   - the read port of the 256x32 operand SRAM (sram_en / sram_addr / sram_data)
//   - the tagged word stream towards the RSA datapath
//     (out_valid / out_ready / out_data / out_sel / out_idx / out_last)
//
// Stream handshake: a word moves only in a cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, the
// producer keeps out_data, out_sel, out_idx and out_last unchanged. out_valid
// never depends on out_ready; out_ready may depend on out_valid.
//
// Modports:
//   master : the fetch sequencer (drives SRAM en/addr and the stream)
//   slave  : the SRAM + datapath side (returns sram_data and out_ready)
//
// Parameter:
//   IDX_W  : width of out_idx, log2 of the words per segment
// ---------------------------------------------------------------------------
interface rsa_sram_fetch_ctrl_if #(
    parameter int IDX_W = 6
);
    // SRAM read port
    logic             sram_en;
    logic [7:0]       sram_addr;
    logic [31:0]      sram_data;

    // Tagged word stream to the RSA core
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_sel;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output sram_en,
        output sram_addr,
        input  sram_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sel,
        output out_idx,
        output out_last
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sel,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/rsa_sram_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_sram_fetch_ctrl
//
// Read sequencer between the 256x32 operand SRAM and the RSA datapath. One
// pass streams the modulus N, then the key, then the message blocks, each a
// segment of WORDS words, as a valid/ready stream tagged with segment and
// index. Core backpressure is absorbed by simply not issuing the next SRAM
// read: the SRAM holds its output while sram_en is low, so the presented word
// stays put until it is accepted.
//
// Parameters:
//   WORDS     : words per segment (power of two, 2..64)
//   DATA_BASE : SRAM base address of the message blocks
//   KEY_BASE  : SRAM base address of the E/D key
//   MOD_BASE  : SRAM base address of the modulus N
//
// Ports:
//   clk       : clock, all state on the rising edge
//   rst       : asynchronous active-high reset
//   start     : one-cycle pass request, ignored while busy
//   abort     : synchronous cancel of the current pass (no done pulse)
//   busy      : pass in progress (STREAM or DONE)
//   done      : one-cycle pulse after the final word's handshake
//   dbg_state : current FSM state (0 IDLE, 1 STREAM, 2 DONE)
//   bus       : SRAM read port and tagged output stream (master side)
// ---------------------------------------------------------------------------
module rsa_sram_fetch_ctrl #(
    parameter int WORDS     = 64,
    parameter int DATA_BASE = 0,
    parameter int KEY_BASE  = 64,
    parameter int MOD_BASE  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state,
    rsa_sram_fetch_ctrl_if.master bus
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORDS - 1);

    // Bases are reduced to the 8-bit SRAM address space; base+idx wraps
    // past 255 silently.
    localparam logic [7:0] MOD_B  = 8'(MOD_BASE);
    localparam logic [7:0] KEY_B  = 8'(KEY_BASE);
    localparam logic [7:0] DATA_B = 8'(DATA_BASE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Segment tag values double as the out_sel encoding.
    typedef enum logic [1:0] {
        SEG_MOD  = 2'd0,
        SEG_KEY  = 2'd1,
        SEG_DATA = 2'd2
    } seg_t;

    state_t           state_q, state_d;
    seg_t             seg_q, seg_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Combinational outputs
    logic             sram_en_c;
    logic [7:0]       sram_addr_c;
    logic             out_valid_c;
    logic             done_c;

    // Position bookkeeping for the word currently on the stream
    logic             idx_wrap;
    logic             final_word;
    logic             handshake;
    seg_t             nxt_seg;
    logic [IDX_W-1:0] nxt_idx;

    // -----------------------------------------------------------------------
    // Address of word (s, i): segment base plus index, truncated to 8 bits.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] word_addr(input seg_t s, input logic [IDX_W-1:0] i);
        logic [7:0] base;
        case (s)
            SEG_MOD: base = MOD_B;
            SEG_KEY: base = KEY_B;
            default: base = DATA_B;
        endcase
        return base + 8'(i);
    endfunction

    // Segment order MOD -> KEY -> DATA. DATA has no successor; the final
    // word's handshake leaves the stream before this would be used.
    function automatic seg_t seg_after(input seg_t s);
        case (s)
            SEG_MOD: return SEG_KEY;
            SEG_KEY: return SEG_DATA;
            default: return SEG_DATA;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next-position logic
    // -----------------------------------------------------------------------
    assign idx_wrap   = (idx_q == IDX_MAX);
    assign final_word = (seg_q == SEG_DATA) && idx_wrap;
    assign nxt_idx    = idx_wrap ? '0 : idx_q + IDX_W'(1);
    assign nxt_seg    = idx_wrap ? seg_after(seg_q) : seg_q;
    assign handshake  = out_valid_c && bus.out_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seg_q   <= SEG_MOD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            idx_q   <= idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    //
    // The SRAM read for a word is issued in the cycle the previous word is
    // accepted (or in the launch cycle for MOD[0]), so the new word shows up
    // on sram_data exactly when seg/idx step to it. Without a handshake no
    // read is issued and the SRAM output, hence out_data, holds.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        idx_d       = idx_q;
        sram_en_c   = 1'b0;
        sram_addr_c = 8'd0;
        out_valid_c = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // abort outranks start while idle
                if (start && !abort) begin
                    state_d     = ST_STREAM;
                    seg_d       = SEG_MOD;
                    idx_d       = '0;
                    sram_en_c   = 1'b1;
                    sram_addr_c = word_addr(SEG_MOD, '0);
                end
            end

            ST_STREAM: begin
                out_valid_c = 1'b1;
                if (abort) begin
                    // Any word offered this cycle counts as not transferred.
                    state_d = ST_IDLE;
                    seg_d   = SEG_MOD;
                    idx_d   = '0;
                end else if (bus.out_ready) begin
                    if (final_word) begin
                        state_d = ST_DONE;
                    end else begin
                        seg_d       = nxt_seg;
                        idx_d       = nxt_idx;
                        sram_en_c   = 1'b1;
                        sram_addr_c = word_addr(nxt_seg, nxt_idx);
                    end
                end
            end

            ST_DONE: begin
                done_c  = !abort;
                state_d = ST_IDLE;
                seg_d   = SEG_MOD;
                idx_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                seg_d   = SEG_MOD;
                idx_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_c;
    assign dbg_state     = state_q;

    assign bus.sram_en   = sram_en_c;
    assign bus.sram_addr = sram_addr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = bus.sram_data;
    assign bus.out_sel   = seg_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_valid_c && final_word;

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    // A stalled word keeps its tag until accepted or aborted.
    stall_holds_tag: assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready && !abort)
            |=> ($stable(bus.out_sel) && $stable(bus.out_idx) && bus.out_valid)
    );

    // done is a single-cycle pulse that ends the pass.
    done_ends_pass: assert property (
        @(posedge clk) disable iff (rst)
        done |=> (!busy && !done)
    );

    // A read is only issued to launch a pass or to follow an accepted word.
    read_has_cause: assert property (
        @(posedge clk) disable iff (rst)
        bus.sram_en |-> ((state_q == ST_IDLE && start) || (handshake && !abort))
    );

endmodule
